// File: rtl/key_pkg.sv
// Shared definitions for the key debouncer: per-key FSM state encoding and
// the pin level that corresponds to a released key.
package key_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS_DB  = 3'd1,
    HELD      = 3'd2,
    LONG_HELD = 3'd3,
    REL_DB    = 3'd4
  } key_state_t;

  // Raw pin level of a key that is not pressed.
  function automatic logic released_level(input bit active_low);
    return active_low;
  endfunction

endpackage

// File: rtl/key_channel.sv
// One key: 2-FF synchroniser, debounce/hold FSM and its counters.
// Auto-repeat logic is only built when KEY_AUTOREPEAT_EN is defined.
module key_channel
  import key_pkg::*;
#(
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned LONG_CYCLES     = 50000000,
  parameter int unsigned REPEAT_CYCLES   = 10000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic key_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic press_set
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned HOLD_W = $clog2(LONG_CYCLES);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 2");
  end
  if (LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_long
    $error("LONG_CYCLES must exceed DEBOUNCE_CYCLES");
  end
  if (REPEAT_CYCLES < 2) begin : g_bad_repeat
    $error("REPEAT_CYCLES must be at least 2");
  end

  logic              sync1_reg, sync2_reg;
  logic              p;
  key_state_t        state_reg, state_next;
  logic [DB_W-1:0]   db_cnt_reg, db_cnt_next;
  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic              origin_long_reg, origin_long_next;
  logic              level_next, release_set, long_set;

`ifdef KEY_AUTOREPEAT_EN
  localparam int unsigned REP_W = $clog2(REPEAT_CYCLES);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
  logic [REP_W-1:0] rep_cnt_reg, rep_cnt_next;
  logic             repeat_set;
`endif

  assign p = sync2_reg ^ ACTIVE_LOW;

  always_comb begin
    state_next       = state_reg;
    db_cnt_next      = db_cnt_reg;
    hold_cnt_next    = hold_cnt_reg;
    origin_long_next = origin_long_reg;
    level_next       = key_level;
    press_set        = 1'b0;
    release_set      = 1'b0;
    long_set         = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
    rep_cnt_next     = rep_cnt_reg;
    repeat_set       = 1'b0;
`endif
    unique case (state_reg)
      IDLE: begin
        if (p) begin
          state_next  = PRESS_DB;
          db_cnt_next = '0;
        end
      end
      PRESS_DB: begin
        if (!p) begin
          state_next  = IDLE;
          db_cnt_next = '0;
        end else if (db_cnt_reg == DB_LAST) begin
          state_next       = HELD;
          level_next       = 1'b1;
          press_set        = 1'b1;
          hold_cnt_next    = '0;
          origin_long_next = 1'b0;
        end else begin
          db_cnt_next = db_cnt_reg + 1'b1;
        end
      end
      HELD: begin
        if (!p) begin
          state_next  = REL_DB;
          db_cnt_next = '0;
        end else if (hold_cnt_reg == HOLD_LAST) begin
          state_next       = LONG_HELD;
          long_set         = 1'b1;
          origin_long_next = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
          rep_cnt_next     = '0;
`endif
        end else begin
          hold_cnt_next = hold_cnt_reg + 1'b1;
        end
      end
      LONG_HELD: begin
        if (!p) begin
          state_next  = REL_DB;
          db_cnt_next = '0;
        end
`ifdef KEY_AUTOREPEAT_EN
        else if (rep_cnt_reg == REP_LAST) begin
          repeat_set   = 1'b1;
          rep_cnt_next = '0;
        end else begin
          rep_cnt_next = rep_cnt_reg + 1'b1;
        end
`endif
      end
      REL_DB: begin
        // A bounce back to pressed resumes the hold as if this cycle had been held.
        if (p) begin
          if (origin_long_reg) begin
            state_next = LONG_HELD;
`ifdef KEY_AUTOREPEAT_EN
            rep_cnt_next = '0;
`endif
          end else if (hold_cnt_reg == HOLD_LAST) begin
            state_next       = LONG_HELD;
            long_set         = 1'b1;
            origin_long_next = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
            rep_cnt_next     = '0;
`endif
          end else begin
            state_next    = HELD;
            hold_cnt_next = hold_cnt_reg + 1'b1;
          end
        end else if (db_cnt_reg == DB_LAST) begin
          state_next  = IDLE;
          level_next  = 1'b0;
          release_set = 1'b1;
          db_cnt_next = '0;
        end else begin
          db_cnt_next = db_cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg       <= released_level(ACTIVE_LOW);
      sync2_reg       <= released_level(ACTIVE_LOW);
      state_reg       <= IDLE;
      db_cnt_reg      <= '0;
      hold_cnt_reg    <= '0;
      origin_long_reg <= 1'b0;
      key_level       <= 1'b0;
      press_pulse     <= 1'b0;
      release_pulse   <= 1'b0;
      long_pulse      <= 1'b0;
    end else begin
      sync1_reg       <= key_in;
      sync2_reg       <= sync1_reg;
      state_reg       <= state_next;
      db_cnt_reg      <= db_cnt_next;
      hold_cnt_reg    <= hold_cnt_next;
      origin_long_reg <= origin_long_next;
      key_level       <= level_next;
      press_pulse     <= press_set;
      release_pulse   <= release_set;
      long_pulse      <= long_set;
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt_reg  <= '0;
      repeat_pulse <= 1'b0;
    end else begin
      rep_cnt_reg  <= rep_cnt_next;
      repeat_pulse <= repeat_set;
    end
  end
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule

// File: rtl/multi_key_debounce.sv
// N_KEYS independent debounced key channels plus a registered any_press flag.
// Optional auto-repeat is enabled by defining KEY_AUTOREPEAT_EN.
module multi_key_debounce #(
  parameter int unsigned N_KEYS          = 4,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned LONG_CYCLES     = 50000000,
  parameter int unsigned REPEAT_CYCLES   = 10000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] long_pulse,
  output logic [N_KEYS-1:0] repeat_pulse,
  output logic              any_press
);

  logic [N_KEYS-1:0] press_set;

  for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_chan
    key_channel #(
      .ACTIVE_LOW      (ACTIVE_LOW),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_chan (
      .clk           (clk),
      .rst_n         (rst_n),
      .key_in        (key_in[gi]),
      .key_level     (key_level[gi]),
      .press_pulse   (press_pulse[gi]),
      .release_pulse (release_pulse[gi]),
      .long_pulse    (long_pulse[gi]),
      .repeat_pulse  (repeat_pulse[gi]),
      .press_set     (press_set[gi])
    );
  end

  // Registered from the channels' next-cycle press so it lines up with press_pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      any_press <= 1'b0;
    end else begin
      any_press <= |press_set;
    end
  end

endmodule
